// File: rtl/lcd_pkg.sv
// Shared types and default geometry for the LCD pixel-stream path.
package lcd_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 480;
    localparam int unsigned V_ACTIVE_DEF   = 272;
    localparam logic [15:0] FILL_COLOR_DEF = 16'h0000;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // FIFO entry: the start-of-frame tag travels with its pixel.
    typedef struct packed {
        logic    sof;
        rgb565_t pix;
    } pix_word_t;

    localparam int unsigned PIX_WORD_W = $bits(pix_word_t);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/lcd_sync_fifo.sv
// Single-clock FIFO with synchronous flush and combinational head read.
module lcd_sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_c  = (level_q == LW'(DEPTH));
    assign empty_c = (level_q == '0);
    assign rdata_c = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Flush wins over any push or pop in the same cycle.
    assign push_ok = push_i && !full_c  && !flush_i;
    assign pop_ok  = pop_i  && !empty_c && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; entries are only read while level is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_pixel_stream.sv
// Frame-aligned RGB565 pixel source feeding the LCD pins, one pixel per pix_de.
// Optional per-frame/underflow statistics: define LCD_PIXEL_STREAM_STATS_EN.
module lcd_pixel_stream
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic [15:0] FILL_COLOR = FILL_COLOR_DEF
) (
    input  logic                   PixelClk,
    input  logic                   nRST,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [15:0]            s_data,
    input  logic                   s_sof,
    input  logic                   pix_de,
    input  logic                   frame_start,
    output logic                   LCD_DE,
    output logic [4:0]             LCD_R,
    output logic [5:0]             LCD_G,
    output logic [4:0]             LCD_B,
    output logic                   underflow,
    output logic                   sof_err,
    output logic [$clog2(DEPTH):0] level
`ifdef LCD_PIXEL_STREAM_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            underflow_cnt
`endif
);

    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CW        = $clog2(FRAME_PIX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff, cnt_inc;
    pix_word_t     head;
    logic          full, empty;
    logic          push, pop, flush;
    logic          s_ready_c;
    logic          pix_hit, und_hit, sof_hit;
    logic          lcd_de_q;
    rgb565_t       rgb_q;
    logic          underflow_q, sof_err_q;

    lcd_sync_fifo #(
        .WIDTH (PIX_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (PixelClk),
        .rst_ni  (nRST),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({s_sof, s_data}),
        .rdata_c (head),
        .full_c  (full),
        .empty_c (empty),
        .level_o (level)
    );

    // Next-state, FIFO control and per-pixel decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_eff   = cnt_q;
        cnt_inc   = cnt_q + CW'(1);
        s_ready_c = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        pix_hit   = 1'b0;
        und_hit   = 1'b0;
        sof_hit   = 1'b0;
        case (state_q)
            HUNT: begin
                s_ready_c = 1'b1;
                if (s_valid && s_sof) begin
                    push    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                s_ready_c = !full;
                push      = s_valid && !full;
                if (frame_start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                s_ready_c = !full;
                push      = s_valid && !full;
                if (frame_start) begin
                    cnt_eff = '0;
                    cnt_d   = '0;
                end
                cnt_inc = cnt_eff + CW'(1);
                if (pix_de) begin
                    cnt_d = cnt_inc;
                    if (empty) begin
                        und_hit = 1'b1;
                        sof_hit = (cnt_eff == '0);
                    end else begin
                        pop     = 1'b1;
                        // Head must carry sof exactly at pixel 0 of the frame.
                        sof_hit = (head.sof != (cnt_eff == '0));
                        pix_hit = !sof_hit;
                    end
                    if (sof_hit) begin
                        flush   = 1'b1;
                        push    = 1'b0;
                        state_d = HUNT;
                    end else if (cnt_inc == CW'(FRAME_PIX)) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign s_ready = nRST && s_ready_c;

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            lcd_de_q    <= 1'b0;
            rgb_q       <= rgb565_t'(FILL_COLOR);
            underflow_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_de_q    <= pix_de;
            rgb_q       <= pix_hit ? head.pix : rgb565_t'(FILL_COLOR);
            underflow_q <= underflow_q || und_hit;
            sof_err_q   <= sof_err_q || sof_hit;
        end
    end

    assign LCD_DE    = lcd_de_q;
    assign LCD_R     = rgb_q.r;
    assign LCD_G     = rgb_q.g;
    assign LCD_B     = rgb_q.b;
    assign underflow = underflow_q;
    assign sof_err   = sof_err_q;

`ifdef LCD_PIXEL_STREAM_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] und_cnt_q;

    // Frames count completed RUN->FILL passes; underflow count saturates.
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            frame_cnt_q <= '0;
            und_cnt_q   <= '0;
        end else begin
            if (state_q == RUN && state_d == FILL) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (und_hit && und_cnt_q != 16'hFFFF)  und_cnt_q   <= und_cnt_q + 16'd1;
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign underflow_cnt = und_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_pixel_stream.sv
// Directed bench for lcd_pixel_stream on a reduced 16x8 panel geometry.
module tb_lcd_pixel_stream;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned H_ACT = 16;
    localparam int unsigned V_ACT = 8;
    localparam int          FRAME = H_ACT * V_ACT;
    localparam logic [15:0] FILLC = 16'hF81F;

    logic        clk = 1'b0;
    logic        nrst, s_valid, s_sof, pix_de, frame_start;
    logic [15:0] s_data;
    logic        s_ready, lcd_de, underflow, sof_err;
    logic [4:0]  lcd_r, lcd_b;
    logic [5:0]  lcd_g;
    logic [6:0]  level;
    logic [15:0] rgb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign rgb = {lcd_r, lcd_g, lcd_b};

    lcd_pixel_stream #(
        .DEPTH      (DEPTH),
        .H_ACTIVE   (H_ACT),
        .V_ACTIVE   (V_ACT),
        .FILL_COLOR (FILLC)
    ) dut (
        .PixelClk    (clk),
        .nRST        (nrst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .pix_de      (pix_de),
        .frame_start (frame_start),
        .LCD_DE      (lcd_de),
        .LCD_R       (lcd_r),
        .LCD_G       (lcd_g),
        .LCD_B       (lcd_b),
        .underflow   (underflow),
        .sof_err     (sof_err),
        .level       (level)
    );

    typedef struct {
        logic        nrst, valid, sof, de, fs;
        logic [15:0] data;
        logic        exp_ready;
        logic [6:0]  exp_level;
        logic        exp_de;
        logic [15:0] exp_rgb;
        logic        exp_und, exp_serr;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(input logic nr, input logic v, input logic sf, input logic de,
                                input logic fs, input logic [15:0] d, input logic rdy,
                                input logic [6:0] lvl, input logic ode, input logic [15:0] orgb,
                                input logic und, input logic serr);
        vec_t t;
        t.nrst = nr; t.valid = v; t.sof = sf; t.de = de; t.fs = fs; t.data = d;
        t.exp_ready = rdy; t.exp_level = lvl; t.exp_de = ode; t.exp_rgb = orgb;
        t.exp_und = und; t.exp_serr = serr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic nr, input logic v, input logic sf, input logic de,
                         input logic fs, input logic [15:0] d);
        nrst = nr; s_valid = v; s_sof = sf; pix_de = de; frame_start = fs; s_data = d;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, " de"},    32'(lcd_de),    32'd0);
        chk({tag, " rgb"},   32'(rgb),       32'(FILLC));
        chk({tag, " level"}, 32'(level),     32'd0);
        chk({tag, " und"},   32'(underflow), 32'd0);
        chk({tag, " serr"},  32'(sof_err),   32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("rst ready low", 32'(s_ready), 32'd0);
        tick();
        chk_idle_reset("rst");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("rst ready release", 32'(s_ready), 32'd1);
    endtask

    // Streams one frame (data = index, sof on word 0) with a queue model of the FIFO.
    task automatic run_frame(input int stall_at, input int resume_at);
        logic [16:0] q[$];
        logic [16:0] w;
        logic [15:0] exp_rgb;
        int          widx;
        int          s;
        bit          exp_und, exp_ready, de, fs, prod;
        widx    = 0;
        exp_und = 1'b0;
        do_reset();
        for (int c = 0; c < 31 + FRAME; c++) begin
            s    = c - 31;
            de   = (s >= 0);
            fs   = (c == 30);
            prod = (widx < FRAME) && (widx < stall_at || s >= resume_at);
            drive(1'b1, prod, widx == 0, de, fs, 16'(widx));
            #1;
            exp_ready = (q.size() < DEPTH);
            chk($sformatf("frame c%0d ready", c), 32'(s_ready), 32'(exp_ready));
            exp_rgb = FILLC;
            if (de) begin
                if (q.size() > 0) begin
                    w       = q.pop_front();
                    exp_rgb = w[15:0];
                end else begin
                    exp_und = 1'b1;
                end
            end
            if (prod && exp_ready) begin
                q.push_back({widx == 0, 16'(widx)});
                widx++;
            end
            tick();
            chk($sformatf("frame c%0d de", c),    32'(lcd_de),    32'(de));
            chk($sformatf("frame c%0d rgb", c),   32'(rgb),       32'(exp_rgb));
            chk($sformatf("frame c%0d level", c), 32'(level),     32'(q.size()));
            chk($sformatf("frame c%0d und", c),   32'(underflow), 32'(exp_und));
            chk($sformatf("frame c%0d serr", c),  32'(sof_err),   32'd0);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        //            nr  v  sof de fs data      rdy lvl de rgb     und serr
        tv[0]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, FILLC,   0, 0);
        tv[1]  = mk(0, 1, 1, 1, 0, 16'h0001, 0, 0, 0, FILLC,   0, 0);
        tv[2]  = mk(1, 1, 0, 0, 0, 16'h1234, 1, 0, 0, FILLC,   0, 0);
        tv[3]  = mk(1, 1, 0, 1, 0, 16'h1235, 1, 0, 1, FILLC,   0, 0);
        tv[4]  = mk(1, 0, 0, 0, 1, 16'h0000, 1, 0, 0, FILLC,   0, 0);
        tv[5]  = mk(1, 1, 1, 0, 0, 16'hABCD, 1, 1, 0, FILLC,   0, 0);
        tv[6]  = mk(1, 1, 0, 1, 0, 16'h1111, 1, 2, 1, FILLC,   0, 0);
        tv[7]  = mk(1, 0, 0, 0, 1, 16'h0000, 1, 2, 0, FILLC,   0, 0);
        tv[8]  = mk(1, 0, 0, 1, 0, 16'h0000, 1, 1, 1, 16'hABCD, 0, 0);
        tv[9]  = mk(1, 1, 0, 1, 0, 16'h2222, 1, 1, 1, 16'h1111, 0, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 16'h0000, 1, 1, 0, FILLC,   0, 0);
        tv[11] = mk(1, 0, 0, 1, 0, 16'h0000, 1, 0, 1, 16'h2222, 0, 0);
        tv[12] = mk(1, 1, 0, 1, 0, 16'h3333, 1, 1, 1, FILLC,   1, 0);
        tv[13] = mk(1, 1, 1, 1, 0, 16'h4444, 1, 1, 1, 16'h3333, 1, 0);
        tv[14] = mk(1, 0, 0, 1, 0, 16'h0000, 1, 0, 1, FILLC,   1, 1);
        tv[15] = mk(1, 1, 0, 0, 0, 16'h5555, 1, 0, 0, FILLC,   1, 1);

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].nrst, tv[i].valid, tv[i].sof, tv[i].de, tv[i].fs, tv[i].data);
            #1;
            chk($sformatf("vec%0d ready", i), 32'(s_ready), 32'(tv[i].exp_ready));
            tick();
            chk($sformatf("vec%0d level", i), 32'(level),     32'(tv[i].exp_level));
            chk($sformatf("vec%0d de", i),    32'(lcd_de),    32'(tv[i].exp_de));
            chk($sformatf("vec%0d rgb", i),   32'(rgb),       32'(tv[i].exp_rgb));
            chk($sformatf("vec%0d und", i),   32'(underflow), 32'(tv[i].exp_und));
            chk($sformatf("vec%0d serr", i),  32'(sof_err),   32'(tv[i].exp_serr));
        end

        // Clean frame, then confirm the block parked in FILL (non-sof word kept, no pop).
        run_frame(FRAME, FRAME + 1000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5A5A);
        #1;
        chk("post ready", 32'(s_ready), 32'd1);
        tick();
        chk("post fill level", 32'(level), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        chk("post fill nopop level", 32'(level), 32'd1);
        chk("post fill rgb", 32'(rgb), 32'(FILLC));
        chk("post fill de", 32'(lcd_de), 32'd1);

        // Producer stalls after 100 words and resumes mid-frame.
        run_frame(100, 110);

        // Head without sof at pixel 0 after a frame_start restart.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA000); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hB000); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC000); tick();
        chk("mis level3", 32'(level), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
        chk("mis pix0 rgb", 32'(rgb), 32'hA000);
        chk("mis pix0 serr", 32'(sof_err), 32'd0);
        chk("mis pix0 level", 32'(level), 32'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
        chk("mis serr", 32'(sof_err), 32'd1);
        chk("mis flush level", 32'(level), 32'd0);
        chk("mis rgb", 32'(rgb), 32'(FILLC));
        chk("mis de", 32'(lcd_de), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, i == 0, 16'hD000 + 16'(i));
            #1;
            chk($sformatf("hunt%0d ready", i), 32'(s_ready), 32'd1);
            tick();
            chk($sformatf("hunt%0d rgb", i),   32'(rgb),       32'(FILLC));
            chk($sformatf("hunt%0d level", i), 32'(level),     32'd0);
            chk($sformatf("hunt%0d und", i),   32'(underflow), 32'd0);
        end

        // Fill to DEPTH, then pop/push around the full boundary.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 16'h0100 + 16'(i));
            tick();
        end
        chk("full level", 32'(level), 32'd64);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0BAD);
        #1;
        chk("full ready", 32'(s_ready), 32'd0);
        tick();
        chk("full refuse level", 32'(level), 32'd64);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("full pop ready", 32'(s_ready), 32'd0);
        tick();
        chk("full pop level", 32'(level), 32'd63);
        chk("full pop rgb", 32'(rgb), 32'h0100);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200);
        #1;
        chk("pushpop ready", 32'(s_ready), 32'd1);
        tick();
        chk("pushpop level", 32'(level), 32'd63);
        chk("pushpop rgb", 32'(rgb), 32'h0101);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0201);
        tick();
        chk("refill level", 32'(level), 32'd64);
        chk("refill ready", 32'(s_ready), 32'd0);

        // One-cycle reset in the middle of a running frame.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300);
        #1;
        chk("mid rst ready", 32'(s_ready), 32'd0);
        tick();
        chk_idle_reset("mid rst");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("mid rst hunt ready", 32'(s_ready), 32'd1);
        tick();
        chk("mid rst level", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
